mem_stage: RTL and testbench

- MEM stage of the 5-stage RISC-V pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Performs word loads and stores on a variable-latency data memory through a req/ack handshake, and stalls the upstream pipeline while an access is outstanding.
- Contains the MEM/WB pipeline register that feeds the writeback mux.
- Flags misaligned word accesses and memory timeouts.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/memwb_reg.sv | 47 ++++
 rtl/mem_stage.sv | 148 ++++++++++++++
 tb/tb_mem_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and widths for the pipeline datapath stages.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int REGADDR_W = 5;
  localparam int CNT_W     = 8;

  // MEM-stage access sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } mem_state_t;

  // Word accesses need the two low byte-address bits clear
  function automatic logic word_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register with bubble insertion and a separately enabled load-data field.
// Latency: 1 cycle, loads on every rising edge.
// Backpressure: none; a bubble clears the writeback controls and holds the data fields.
// Ports: clk/rst (sync, active-high); bubble; reg_write/mem_to_reg/alu_res/rd_addr in;
//        mem_data_en/mem_data in; wb_* registered outputs to the writeback mux.
module memwb_reg
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bubble,
  input  logic                 reg_write,
  input  logic                 mem_to_reg,
  input  logic [XLEN-1:0]      alu_res,
  input  logic [REGADDR_W-1:0] rd_addr,
  input  logic                 mem_data_en,
  input  logic [XLEN-1:0]      mem_data,
  output logic                 wb_reg_write,
  output logic                 wb_mem_to_reg,
  output logic [XLEN-1:0]      wb_alu_res,
  output logic [XLEN-1:0]      wb_mem_data,
  output logic [REGADDR_W-1:0] wb_rd_addr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_alu_res    <= '0;
      wb_mem_data   <= '0;
      wb_rd_addr    <= '0;
    end else begin
      wb_reg_write  <= reg_write & ~bubble;
      wb_mem_to_reg <= mem_to_reg & ~bubble;
      // Data fields are don't-care under a bubble, so they simply hold
      if (!bubble) begin
        wb_alu_res <= alu_res;
        wb_rd_addr <= rd_addr;
      end
      // Load data only moves when a memory access retires
      if (mem_data_en) begin
        wb_mem_data <= mem_data;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: word load/store over a req/ack data-memory port, feeding the MEM/WB register.
// Latency: 1 cycle for non-memory ops; aligned accesses take 2 + (extra WAIT cycles) stalls plus one DONE cycle.
// Backpressure: stall_o (combinational) freezes upstream while an access is being issued or awaited.
// Ports: clk_i, rst_i (sync, active-high); EX/MEM inputs *_i; dmem_* request/ack port;
//        MEM/WB outputs RegWrite_o/MemtoReg_o/ALUres_o/MemData_o/RDaddr_o; misalign_o pulse, bus_err_o sticky.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 RegWrite_i,
  input  logic                 MemtoReg_i,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic [XLEN-1:0]      ALUres_i,
  input  logic [XLEN-1:0]      RS2data_i,
  input  logic [REGADDR_W-1:0] RDaddr_i,
  output logic                 stall_o,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [XLEN-1:0]      dmem_addr_o,
  output logic [XLEN-1:0]      dmem_wdata_o,
  input  logic                 dmem_ack_i,
  input  logic [XLEN-1:0]      dmem_rdata_i,
  output logic                 RegWrite_o,
  output logic                 MemtoReg_o,
  output logic [XLEN-1:0]      ALUres_o,
  output logic [XLEN-1:0]      MemData_o,
  output logic [REGADDR_W-1:0] RDaddr_o,
  output logic                 misalign_o,
  output logic                 bus_err_o
);

  // Last WAIT count value before the access is abandoned
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             to_flag;
  logic [XLEN-1:0]  rdata_q;

  logic mem_op;
  logic aligned;
  logic start;
  logic wb_bubble;
  logic wb_reg_write;
  logic wb_data_en;

  assign mem_op  = MemRead_i | MemWrite_i;
  assign aligned = word_aligned(ALUres_i[1:0]);
  assign start   = (state == S_IDLE) && mem_op && aligned;
  assign stall_o = start || (state == S_WAIT);

  // What the MEM/WB register captures at the next edge
  always_comb begin
    wb_bubble    = 1'b0;
    wb_reg_write = RegWrite_i;
    wb_data_en   = 1'b0;
    case (state)
      S_IDLE: begin
        wb_bubble = start;
        // Misaligned accesses pass through but must not write back
        if (mem_op) wb_reg_write = 1'b0;
      end
      S_WAIT: wb_bubble = 1'b1;
      S_DONE: begin
        wb_reg_write = RegWrite_i & ~to_flag;
        wb_data_en   = 1'b1;
      end
      default: wb_bubble = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      cnt          <= '0;
      to_flag      <= 1'b0;
      rdata_q      <= '0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_op) begin
            if (aligned) begin
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= MemWrite_i;  // write wins if both set
              dmem_addr_o  <= ALUres_i;
              dmem_wdata_o <= RS2data_i;
              cnt          <= '0;
              state        <= S_WAIT;
            end else begin
              misalign_o <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          // Ack is checked first so an ack on the last count still succeeds
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            if (!dmem_we_o) rdata_q <= dmem_rdata_i;
            state <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            dmem_req_o <= 1'b0;
            bus_err_o  <= 1'b1;
            to_flag    <= 1'b1;
            rdata_q    <= '0;
            state      <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          // Upstream advances on this edge, so the op is never reissued
          to_flag <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  memwb_reg u_memwb (
    .clk           (clk_i),
    .rst           (rst_i),
    .bubble        (wb_bubble),
    .reg_write     (wb_reg_write),
    .mem_to_reg    (MemtoReg_i),
    .alu_res       (ALUres_i),
    .rd_addr       (RDaddr_i),
    .mem_data_en   (wb_data_en),
    .mem_data      (rdata_q),
    .wb_reg_write  (RegWrite_o),
    .wb_mem_to_reg (MemtoReg_o),
    .wb_alu_res    (ALUres_o),
    .wb_mem_data   (MemData_o),
    .wb_rd_addr    (RDaddr_o)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle ops plus hand-written access sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic [31:0] ALUres_i, RS2data_i;
  logic [4:0]  RDaddr_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        RegWrite_o, MemtoReg_o;
  logic [31:0] ALUres_o, MemData_o;
  logic [4:0]  RDaddr_o;
  logic        misalign_o, bus_err_o;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .ALUres_i(ALUres_i), .RS2data_i(RS2data_i), .RDaddr_i(RDaddr_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .ALUres_o(ALUres_o), .MemData_o(MemData_o), .RDaddr_o(RDaddr_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic        rw, m2r, mr, mw;
    logic [31:0] alu, rs2;
    logic [4:0]  rd;
    logic        e_stall, e_rw, e_m2r, e_mis;
    logic [31:0] e_alu;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(input logic rw, input logic m2r, input logic mr, input logic mw,
                        input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd);
    RegWrite_i = rw; MemtoReg_i = m2r; MemRead_i = mr; MemWrite_i = mw;
    ALUres_i = alu; RS2data_i = rs2; RDaddr_i = rd;
    #1;
  endtask

  task automatic set_nop();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  // Runs an already-driven aligned access from IDLE until stall drops (DONE state).
  // ack_after = n acks in the n-th cycle with req high; 0 never acks.
  task automatic run_access(input int ack_after, input logic [31:0] rdata,
                            output int stalls, output int reqs,
                            output logic [31:0] a, output logic w, output logic [31:0] wd);
    logic done;
    done = 1'b0; stalls = 0; reqs = 0; a = '0; w = 1'b0; wd = '0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (!stall_o) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (dmem_req_o) begin
          reqs++;
          if (reqs == 1) begin
            a = dmem_addr_o; w = dmem_we_o; wd = dmem_wdata_o;
          end
          if (reqs == ack_after) begin
            dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
          end
        end
        tick();
        dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
      end
    end
    chk("access_completes", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          stalls, reqs;
    logic [31:0] a, wd;
    logic        w;

    //          rw   m2r  mr   mw   alu           rs2           rd     stall rw   m2r  mis  e_alu         e_rd
    vecs[0] = '{1'b1,1'b0,1'b0,1'b0,32'h0000_1234,32'h0,        5'd5,  1'b0,1'b1,1'b0,1'b0,32'h0000_1234,5'd5};
    vecs[1] = '{1'b0,1'b0,1'b0,1'b0,32'hFFFF_FFFF,32'h1,        5'd31, 1'b0,1'b0,1'b0,1'b0,32'hFFFF_FFFF,5'd31};
    vecs[2] = '{1'b1,1'b1,1'b1,1'b0,32'h0000_0042,32'h0,        5'd7,  1'b0,1'b0,1'b1,1'b1,32'h0000_0042,5'd7};
    vecs[3] = '{1'b1,1'b0,1'b0,1'b0,32'h0000_0003,32'h0,        5'd1,  1'b0,1'b1,1'b0,1'b0,32'h0000_0003,5'd1};
    vecs[4] = '{1'b0,1'b0,1'b0,1'b1,32'h0000_0081,32'h1111_2222,5'd0,  1'b0,1'b0,1'b0,1'b1,32'h0000_0081,5'd0};
    vecs[5] = '{1'b1,1'b0,1'b1,1'b1,32'h0000_0102,32'h0,        5'd9,  1'b0,1'b0,1'b0,1'b1,32'h0000_0102,5'd9};

    // Reset
    rst_i = 1'b1; dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
    set_nop();
    tick(); tick();
    rst_i = 1'b0;
    #1;
    chk("rst_stall",    {31'd0, stall_o},    32'd0);
    chk("rst_req",      {31'd0, dmem_req_o}, 32'd0);
    chk("rst_we",       {31'd0, dmem_we_o},  32'd0);
    chk("rst_addr",     dmem_addr_o,         32'd0);
    chk("rst_wdata",    dmem_wdata_o,        32'd0);
    chk("rst_regwrite", {31'd0, RegWrite_o}, 32'd0);
    chk("rst_alures",   ALUres_o,            32'd0);
    chk("rst_memdata",  MemData_o,           32'd0);
    chk("rst_rd",       {27'd0, RDaddr_o},   32'd0);
    chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
    chk("rst_buserr",   {31'd0, bus_err_o},  32'd0);

    // Single-cycle ops from IDLE
    for (int i = 0; i < 6; i++) begin
      set_in(vecs[i].rw, vecs[i].m2r, vecs[i].mr, vecs[i].mw, vecs[i].alu, vecs[i].rs2, vecs[i].rd);
      chk($sformatf("vec%0d_stall", i), {31'd0, stall_o}, {31'd0, vecs[i].e_stall});
      tick();
      chk($sformatf("vec%0d_regwrite", i), {31'd0, RegWrite_o}, {31'd0, vecs[i].e_rw});
      chk($sformatf("vec%0d_memtoreg", i), {31'd0, MemtoReg_o}, {31'd0, vecs[i].e_m2r});
      chk($sformatf("vec%0d_alures", i),   ALUres_o,            vecs[i].e_alu);
      chk($sformatf("vec%0d_rd", i),       {27'd0, RDaddr_o},   {27'd0, vecs[i].e_rd});
      chk($sformatf("vec%0d_misalign", i), {31'd0, misalign_o}, {31'd0, vecs[i].e_mis});
      chk($sformatf("vec%0d_req", i),      {31'd0, dmem_req_o}, 32'd0);
      chk($sformatf("vec%0d_memdata", i),  MemData_o,           32'd0);
    end
    set_nop();
    tick();
    chk("misalign_pulse_ends", {31'd0, misalign_o}, 32'd0);

    // Load at 0x40, ack in the 3rd WAIT cycle
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd10);
    run_access(3, 32'hDEAD_BEEF, stalls, reqs, a, w, wd);
    chk("ld_stalls", stalls, 32'd4);
    chk("ld_reqs",   reqs,   32'd3);
    chk("ld_addr",   a,      32'h40);
    chk("ld_we",     {31'd0, w}, 32'd0);
    chk("ld_req_done", {31'd0, dmem_req_o}, 32'd0);
    tick();
    set_nop();
    chk("ld_memdata",  MemData_o,           32'hDEAD_BEEF);
    chk("ld_memtoreg", {31'd0, MemtoReg_o}, 32'd1);
    chk("ld_regwrite", {31'd0, RegWrite_o}, 32'd1);
    chk("ld_rd",       {27'd0, RDaddr_o},   32'd10);
    chk("ld_stall_after", {31'd0, stall_o}, 32'd0);

    // Store to 0x80, immediate ack
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'hCAFE_F00D, 5'd0);
    run_access(1, 32'h0, stalls, reqs, a, w, wd);
    chk("st_stalls", stalls, 32'd2);
    chk("st_reqs",   reqs,   32'd1);
    chk("st_addr",   a,      32'h80);
    chk("st_we",     {31'd0, w}, 32'd1);
    chk("st_wdata",  wd,     32'hCAFE_F00D);
    tick();
    set_nop();
    chk("st_regwrite", {31'd0, RegWrite_o}, 32'd0);
    chk("st_buserr",   {31'd0, bus_err_o},  32'd0);

    // Load that never gets an ack: times out after 4 WAIT cycles
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd3);
    run_access(0, 32'h0, stalls, reqs, a, w, wd);
    chk("to_stalls", stalls, 32'd5);
    chk("to_reqs",   reqs,   32'd4);
    chk("to_req_dropped", {31'd0, dmem_req_o}, 32'd0);
    chk("to_buserr", {31'd0, bus_err_o}, 32'd1);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 5'd9);
    chk("to_memdata",  MemData_o,           32'd0);
    chk("to_regwrite", {31'd0, RegWrite_o}, 32'd0);
    chk("alu_after_to_stall", {31'd0, stall_o}, 32'd0);
    tick();
    set_nop();
    chk("alu_after_to_regwrite", {31'd0, RegWrite_o}, 32'd1);
    chk("alu_after_to_alures",   ALUres_o,            32'h55);
    chk("alu_after_to_rd",       {27'd0, RDaddr_o},   32'd9);
    chk("buserr_sticky",         {31'd0, bus_err_o},  32'd1);

    // Reset during WAIT, then a late ack
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd4);
    tick();
    tick();
    chk("rw_in_wait_req", {31'd0, dmem_req_o}, 32'd1);
    rst_i = 1'b1;
    set_nop();
    tick();
    rst_i = 1'b0;
    #1;
    chk("rw_req",      {31'd0, dmem_req_o}, 32'd0);
    chk("rw_addr",     dmem_addr_o,         32'd0);
    chk("rw_buserr",   {31'd0, bus_err_o},  32'd0);
    chk("rw_regwrite", {31'd0, RegWrite_o}, 32'd0);
    chk("rw_memdata",  MemData_o,           32'd0);
    chk("rw_stall",    {31'd0, stall_o},    32'd0);
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hBAD0_BAD0;
    tick();
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
    tick();
    chk("late_ack_req",     {31'd0, dmem_req_o}, 32'd0);
    chk("late_ack_stall",   {31'd0, stall_o},    32'd0);
    chk("late_ack_memdata", MemData_o,           32'd0);

    // Next load after reset completes normally
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd12);
    run_access(1, 32'h1357_9BDF, stalls, reqs, a, w, wd);
    chk("ld2_stalls", stalls, 32'd2);
    chk("ld2_addr",   a,      32'h44);
    tick();
    set_nop();
    chk("ld2_memdata",  MemData_o,           32'h1357_9BDF);
    chk("ld2_regwrite", {31'd0, RegWrite_o}, 32'd1);
    chk("ld2_rd",       {27'd0, RDaddr_o},   32'd12);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
